// File: rtl/contador_param.sv
// contador_param: N-bit synchronous counter.
// Modes are up, down, down-by-STEP and parallel load. A cascade carry-in
// gates the counting modes, and the wrap behaviour can either saturate or
// roll over. TC is a combinational lookahead of the next wrap, so stages can
// be chained by feeding each stage's TC into the next stage's CI.
module contador_param #(
    parameter int WIDTH = 16,
    parameter int STEP  = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    input  logic             CI,
    input  logic             SAT,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             TC,
    output logic             OVF
);

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DN   = 2'b01;
    localparam logic [1:0] MODO_DNS  = 2'b10;
    localparam logic [1:0] MODO_LOAD = 2'b11;

    // STEP is reduced to the counter width once, at elaboration.
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic             wrap;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_clamp;
    logic [WIDTH-1:0] q_nxt;
    logic             rco_nxt;
    logic             ovf_nxt;

    // Wrap condition, modulo step result and saturation limit for the current mode.
    always_comb begin
        wrap    = 1'b0;
        q_step  = Q;
        q_clamp = '0;
        case (MODO)
            MODO_UP: begin
                wrap    = (Q == ALL_ONES);
                q_step  = Q + 1'b1;
                q_clamp = ALL_ONES;
            end
            MODO_DN: begin
                wrap    = (Q == '0);
                q_step  = Q - 1'b1;
            end
            MODO_DNS: begin
                wrap    = (Q < STEP_W);
                q_step  = Q - STEP_W;
            end
            default: begin
                wrap    = 1'b0;
                q_step  = Q;
            end
        endcase
    end

    // The lookahead depends only on Q, ENB, MODO and CI. It never depends on D or SAT.
    always_comb begin
        TC = ENB & CI & wrap;
    end

    // Next-state selection. Load wins over everything else. In all other
    // modes D is never looked at, so an unknown D cannot reach Q.
    always_comb begin
        q_nxt   = Q;
        rco_nxt = 1'b0;
        ovf_nxt = OVF;
        if (ENB) begin
            if (MODO == MODO_LOAD) begin
                q_nxt   = D;
                ovf_nxt = 1'b0;
            end else if (CI) begin
                if (wrap) begin
                    rco_nxt = 1'b1;
                    ovf_nxt = 1'b1;
                    q_nxt   = SAT ? q_clamp : q_step;
                end else begin
                    q_nxt   = q_step;
                end
            end
        end
    end

    // Count, carry-out and sticky overflow registers. Reset is asynchronous.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q   <= '0;
            RCO <= 1'b0;
            OVF <= 1'b0;
        end else begin
            Q   <= q_nxt;
            RCO <= rco_nxt;
            OVF <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_contador_param.sv
// tb_contador_param: directed and random checks of contador_param against an
// arithmetic reference model. Also covers a two-stage 4-bit chain.
module tb_contador_param;

    localparam int  STEP = 3;
    localparam longint MAXV = 65535;

    logic        clk;
    logic        rst;
    logic        enb;
    logic [1:0]  modo;
    logic [15:0] d;
    logic        ci;
    logic        sat;
    logic [15:0] q;
    logic        rco;
    logic        tc;
    logic        ovf;

    logic        c_enb;
    logic [1:0]  c_modo;
    logic [3:0]  c_d;
    logic [3:0]  q_lo, q_hi;
    logic        rco_lo, rco_hi, tc_lo, tc_hi, ovf_lo, ovf_hi;

    int total = 0;
    int bad   = 0;

    longint mq;
    bit     mrco;
    bit     movf;

    contador_param #(.WIDTH(16), .STEP(STEP)) dut (
        .CLK(clk), .RST(rst), .ENB(enb), .MODO(modo), .D(d), .CI(ci), .SAT(sat),
        .Q(q), .RCO(rco), .TC(tc), .OVF(ovf)
    );

    contador_param #(.WIDTH(4), .STEP(1)) lo (
        .CLK(clk), .RST(rst), .ENB(c_enb), .MODO(c_modo), .D(c_d), .CI(1'b1), .SAT(1'b0),
        .Q(q_lo), .RCO(rco_lo), .TC(tc_lo), .OVF(ovf_lo)
    );

    contador_param #(.WIDTH(4), .STEP(1)) hi (
        .CLK(clk), .RST(rst), .ENB(c_enb), .MODO(c_modo), .D(c_d), .CI(tc_lo), .SAT(1'b0),
        .Q(q_hi), .RCO(rco_hi), .TC(tc_hi), .OVF(ovf_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Unbounded result of one counting step. A result outside 0..MAXV is a wrap.
    function automatic longint raw_step(input logic [1:0] m, input longint v);
        case (m)
            2'b00:   return v + 1;
            2'b01:   return v - 1;
            2'b10:   return v - STEP;
            default: return v;
        endcase
    endfunction

    function automatic bit model_tc(input bit e, input logic [1:0] m, input bit c);
        longint r;
        r = raw_step(m, mq);
        return e && c && (m != 2'b11) && (r < 0 || r > MAXV);
    endfunction

    task automatic model_update(input bit e, input logic [1:0] m, input logic [15:0] dv,
                                input bit c, input bit s);
        longint r;
        mrco = 1'b0;
        if (e) begin
            if (m == 2'b11) begin
                mq   = longint'(dv);
                movf = 1'b0;
            end else if (c) begin
                r = raw_step(m, mq);
                if (r < 0 || r > MAXV) begin
                    mrco = 1'b1;
                    movf = 1'b1;
                    if (s) mq = (m == 2'b00) ? MAXV : 0;
                    else   mq = (r < 0) ? r + MAXV + 1 : r - (MAXV + 1);
                end else begin
                    mq = r;
                end
            end
        end
    endtask

    // Drive one set of inputs, check the lookahead, clock once, then check the registers.
    task automatic do_step(input bit e, input logic [1:0] m, input logic [15:0] dv,
                           input bit c, input bit s);
        enb = e; modo = m; d = dv; ci = c; sat = s;
        #1;
        chk("tc", {31'b0, tc}, {31'b0, model_tc(e, m, c)});
        @(posedge clk);
        #1;
        model_update(e, m, dv, c, s);
        chk("q", {16'b0, q}, 32'(mq));
        chk("rco", {31'b0, rco}, {31'b0, mrco});
        chk("ovf", {31'b0, ovf}, {31'b0, movf});
    endtask

    initial begin
        logic [1:0]  rm;
        logic [15:0] rd;
        int          cnt;

        rst = 1'b1; enb = 1'b0; modo = 2'b00; d = '0; ci = 1'b1; sat = 1'b0;
        c_enb = 1'b0; c_modo = 2'b00; c_d = '0;
        mq = 0; mrco = 0; movf = 0;
        #2;
        chk("rst_q", {16'b0, q}, 32'h0);
        chk("rst_rco", {31'b0, rco}, 32'h0);
        chk("rst_ovf", {31'b0, ovf}, 32'h0);
        chk("rst_chain", {24'b0, q_hi, q_lo}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Up count across the top boundary.
        do_step(1, 2'b11, 16'hFFFD, 1, 0);
        for (int i = 0; i < 4; i++) do_step(1, 2'b00, 16'hxxxx, 1, 0);
        chk("up_end_q", {16'b0, q}, 32'h0001);
        chk("up_end_ovf", {31'b0, ovf}, 32'h1);

        // Down by STEP, modulo and then saturating.
        do_step(1, 2'b11, 16'h0004, 1, 0);
        for (int i = 0; i < 3; i++) do_step(1, 2'b10, 16'hxxxx, 1, 0);
        chk("dns_wrap_q", {16'b0, q}, 32'hFFFB);
        do_step(1, 2'b11, 16'h0004, 1, 1);
        for (int i = 0; i < 3; i++) do_step(1, 2'b10, 16'hxxxx, 1, 1);
        chk("dns_sat_q", {16'b0, q}, 32'h0000);
        chk("dns_sat_rco", {31'b0, rco}, 32'h1);

        // Loads clear OVF and track D one cycle late.
        for (int i = 0; i < 16; i++) do_step(1, 2'b11, 16'(i), 1, 0);

        // Enable low, then carry-in low: the counter must hold.
        do_step(1, 2'b11, 16'hFFFF, 1, 0);
        for (int i = 0; i < 3; i++) do_step(0, 2'b00, 16'h1111, 1, 0);
        for (int i = 0; i < 3; i++) do_step(1, 2'b00, 16'h2222, 0, 0);
        chk("hold_q", {16'b0, q}, 32'hFFFF);

        // Random traffic. Loads are biased toward the limits so that wraps occur often.
        for (int i = 0; i < 400; i++) begin
            rm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0)
                rd = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 4))
                                                  : 16'(16'hFFFB + $urandom_range(0, 4));
            else
                rd = 16'($urandom);
            if (rm != 2'b11 && $urandom_range(0, 3) == 0) rd = 'x;
            do_step($urandom_range(0, 7) != 0, rm, rd, $urandom_range(0, 5) != 0,
                    1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while counting at 1234.
        do_step(1, 2'b11, 16'h1233, 1, 0);
        do_step(1, 2'b00, 16'hxxxx, 1, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_q", {16'b0, q}, 32'h0);
        chk("arst_rco", {31'b0, rco}, 32'h0);
        chk("arst_ovf", {31'b0, ovf}, 32'h0);
        mq = 0; mrco = 0; movf = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        do_step(1, 2'b01, 16'hxxxx, 1, 0);
        chk("arst_first_q", {16'b0, q}, 32'hFFFF);
        chk("arst_first_rco", {31'b0, rco}, 32'h1);

        // Two 4-bit stages chained through TC -> CI.
        enb = 1'b0;
        c_enb = 1'b1; c_modo = 2'b11; c_d = 4'h0;
        @(posedge clk); #1;
        c_modo = 2'b00;
        cnt = 0;
        for (int i = 0; i < 260; i++) begin
            #1;
            chk("chain_tc_lo", {31'b0, tc_lo}, {31'b0, (cnt % 16) == 15});
            @(posedge clk); #1;
            cnt = (cnt + 1) % 256;
            chk("chain_q", {24'b0, q_hi, q_lo}, 32'(cnt));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/contador_param.md
# contador_param

Parametrised N-bit synchronous counter with selectable count mode, configurable down-step, parallel load, a cascade carry-in, a lookahead terminal-count output and optional saturation. It generalises the team's fixed 4-bit and 16-bit mode counters (up, down, down-by-3, load). One instance replaces a chain of narrow counters. The TC/CI pair also lets several instances be chained without ripple latency.

## Interface
- WIDTH, 16, counter width in bits (≥ 2)
- STEP, 3, decrement for mode 2'b10 (1 ≤ STEP ≤ 2^WIDTH − 1)
- CLK  input  1  rising-edge clock, the only clock
- RST  input  1  asynchronous, active-high reset
- ENB  input  1  enable; when 0 the counter holds
- MODO  input  2  operation select: 00 up by 1, 01 down by 1, 10 down by STEP, 11 parallel load
- D  input  WIDTH  parallel load value
- CI  input  1  cascade carry-in; gates counting modes only (tie to 1 when unchained)
- SAT  input  1  1 = saturate at limits, 0 = wrap modulo 2^WIDTH
- Q  output  WIDTH  registered count
- RCO  output  1  registered; 1 for one cycle after a wrap or blocked (saturated) step
- TC  output  1  combinational lookahead: the next counting edge will wrap
- OVF  output  1  registered sticky flag: any wrap or saturation since the last load or reset

## Operation
- Reset (RST=1, asynchronous): Q=0, RCO=0, OVF=0, independent of CLK; holds while RST=1.
- ENB=0: Q and OVF hold, RCO=0.
- ENB=1, MODO=11: Q←D, RCO←0, OVF←0. CI and SAT are ignored.
- ENB=1, counting mode, CI=0: Q holds, RCO←0.
- ENB=1, counting mode, CI=1:
  - 00: if Q=all-ones, the step wraps; else Q←Q+1.
  - 01: if Q=0, the step wraps; else Q←Q−1.
  - 10: if Q<STEP, the step wraps; else Q←Q−STEP.
- Wrapping step with SAT=0:
  - Q←(result) mod 2^WIDTH, i.e. up gives 0, down gives all-ones, down-by-STEP gives Q−STEP+2^WIDTH.
  - RCO←1, OVF←1.
- Wrapping step with SAT=1:
  - Q clamps: all-ones for mode 00, 0 for modes 01/10.
  - RCO←1, OVF←1.
  - Repeats every cycle the blocked step is attempted.
- TC = ENB & CI & wrap-condition(MODO, Q). TC is 0 in mode 11.
- Cascade: drive an upper stage's CI from the lower stage's TC. The upper stage then advances on the same edge as the lower stage's wrap.
- All arithmetic is WIDTH bits, unsigned. STEP is truncated to WIDTH bits at elaboration.
- Mode changes take effect on the next edge; there is no internal state beyond Q/RCO/OVF.

## Timing
- Single clock domain; all outputs except TC are updated on the CLK rising edge.
- Latency: one cycle from a sampled ENB/MODO/D/CI to Q and RCO.
- RCO is high exactly in the cycle following the wrapping edge and cannot stay high two cycles unless a wrap occurs on consecutive edges:
  - possible with SAT=1 held at a limit;
  - possible in mode 10 when STEP > 2^(WIDTH−1).
- TC is combinational from Q, ENB, MODO and CI; no path from D or SAT.
- Load and wrap on the same edge cannot coincide (load has priority by MODO encoding).
- RST asserted mid-count clears Q immediately. The first edge after RST deasserts performs the selected operation from Q=0.
- D=X during non-load modes must not propagate to Q.

## Test plan
- Up count, WIDTH=16:
  - Stimulus: load 16'hFFFD, then MODO=00, CI=1, SAT=0 for 4 edges.
  - Required: Q = FFFE, FFFF, 0000, 0001.
  - Required: TC=1 while Q=FFFF; RCO=1 only in the cycle Q=0000; OVF=1 afterwards.
- Down count by STEP=3:
  - Stimulus: load 16'h0004, MODO=10.
  - Required: Q = 0001, then FFFE with RCO=1, then FFFB.
  - Stimulus: reload 16'h0004 with SAT=1.
  - Required: Q = 0001, 0000, 0000. RCO=1 on both clamped cycles.
- Load and OVF clear:
  - Stimulus: with OVF=1, MODO=11, D stepping 0000→000F one value per edge.
  - Required: Q follows D one cycle late; OVF=0 after the first load; RCO=0 throughout.
- Enable and cascade gating:
  - Stimulus: ENB=0 for 3 edges in mode 00, then ENB=1 with CI=0.
  - Required: Q unchanged in both phases, RCO=0, TC=0.
- Two-stage chain, WIDTH=4 each:
  - Setup: lower TC drives upper CI; both count up from 0.
  - Required: upper increments exactly on every 16th edge, in the same edge the lower stage goes F→0. The combined value counts 00→FF→00.
- Asynchronous reset:
  - Stimulus: assert RST mid-cycle while counting at Q=1234.
  - Required: Q=0, RCO=0, OVF=0 before the next CLK edge.
  - Required: after release with MODO=01, the first edge gives Q=FFFF with RCO=1.
